// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ valid/ready requesters, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_result,
  output logic                    busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [NUM_REQ-1:0][3:0]  op_arr;
  logic [NUM_REQ-1:0][31:0] a_arr, b_arr;
  assign op_arr = req_op;
  assign a_arr  = req_a;
  assign b_arr  = req_b;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [3:0]     op_q, op_d;
  logic [31:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [IDW-1:0] start_ptr, win;
  logic           found, owner_ack;

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_XOR:  alu = a ^ b;
      OP_OR:   alu = a | b;
      OP_AND:  alu = a & b;
      OP_SLL:  alu = a << b[4:0];
      OP_SRL:  alu = a >> b[4:0];
      OP_SRA:  alu = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: alu = {31'b0, a < b};
      default: alu = 32'b0;
    endcase
  endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign start_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  assign start_ptr = rr_ptr_q;
`endif

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= start_ptr)) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) < start_ptr)) begin
        found = 1'b1;
        win   = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == S_IDLE) && found && (win == IDW'(i));
      rsp_valid[i] = (state_q == S_RESP) && (owner_q == IDW'(i));
    end
  end

  assign owner_ack  = |(rsp_valid & rsp_ready);
  assign rsp_result = result_q;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: if (found) begin
        owner_d = win;
        op_d    = op_arr[win];
        a_d     = a_arr[win];
        b_d     = b_arr[win];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu(op_q, a_q, b_q);
        state_d  = S_RESP;
      end
      S_RESP: if (owner_ack) begin
        state_d = S_IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_ptr_d = (owner_q == IDW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule
